cam_capture_px: RTL

CAM_CAPTURE_PX -- requirements
Module: cam_capture_px

---
 rtl/cam_pkg.sv | 24 ++
 rtl/cam_px_pack.sv | 29 ++
 rtl/cam_capture_px.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera pixel-capture block: FSM encoding,
// stored-pixel format codes and common frame sizes.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } cam_state_t;

  localparam int FMT_RGB111 = 3;
  localparam int FMT_RGB332 = 8;
  localparam int FMT_RGB444 = 12;

  localparam int QQVGA_H = 160;
  localparam int QQVGA_V = 120;
  localparam int QVGA_H  = 320;
  localparam int QVGA_V  = 240;

  function automatic bit fmt_supported(input int dw);
    return (dw == FMT_RGB111) || (dw == FMT_RGB332) || (dw == FMT_RGB444);
  endfunction

endpackage

// File: rtl/cam_px_pack.sv
// Combinational RGB444 -> DW-bit pixel packing, R in the MSBs.
// Unsupported DW values stop elaboration.
module cam_px_pack
  import cam_pkg::*;
#(
  parameter int DW = FMT_RGB111
) (
  input  logic [3:0]    r,
  input  logic [3:0]    g,
  input  logic [3:0]    b,
  output logic [DW-1:0] px
);

  if (DW == FMT_RGB111) begin : g_rgb111
    logic unused_lsbs;
    assign unused_lsbs = ^{r[2:0], g[2:0], b[2:0]};
    assign px = {r[3], g[3], b[3]};
  end else if (DW == FMT_RGB332) begin : g_rgb332
    logic unused_lsbs;
    assign unused_lsbs = ^{r[0], g[0], b[1:0]};
    assign px = {r[3:1], g[3:1], b[3:2]};
  end else if (DW == FMT_RGB444) begin : g_rgb444
    assign px = {r, g, b};
  end else begin : g_bad_dw
    $error("cam_px_pack: DW=%0d is not 3, 8 or 12", DW);
    assign px = '0;
  end

endmodule

// File: rtl/cam_capture_px.sv
// Camera (VSYNC/HREF/PCLK, RGB444 byte pairs) to pixel-memory write port.
// Define CAM_CAPTURE_DECIM_EN for 2x decimation of a doubled-size input frame.
module cam_capture_px
  import cam_pkg::*;
#(
  parameter int AW       = 15,
  parameter int DW       = FMT_RGB111,
  parameter int H_PIXELS = QQVGA_H,
  parameter int V_LINES  = QQVGA_V
) (
  input  logic          PCLK,
  input  logic          rst,
  input  logic [7:0]    D,
  input  logic          VSYNC,
  input  logic          HREF,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          err_ovf
);

`ifdef CAM_CAPTURE_DECIM_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif
  // Counters run over input coordinates, so limits scale with decimation.
  localparam int COL_LIM = H_PIXELS * SCALE;
  localparam int ROW_LIM = V_LINES * SCALE;
  localparam int CW      = $clog2(COL_LIM + 1);
  localparam int RW      = $clog2(ROW_LIM + 1);
  localparam int BW      = AW + 1;
  localparam logic [CW-1:0] COL_MAX = CW'(COL_LIM);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROW_LIM);
  localparam logic [BW-1:0] ROW_INC = BW'(H_PIXELS);

  if (longint'(H_PIXELS) * longint'(V_LINES) > (longint'(1) << AW)) begin : g_bad_size
    $error("cam_capture_px: H_PIXELS*V_LINES exceeds 2**AW");
  end
  if (!fmt_supported(DW)) begin : g_bad_fmt
    $error("cam_capture_px: DW=%0d unsupported", DW);
  end

  cam_state_t    state, state_nxt;
  logic          start, done;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [BW-1:0] row_base;
  logic          phase;
  logic [3:0]    r_lat;
  logic          href_d;
  logic [DW-1:0] px_packed;
  logic          active, in_range, keep, row_step;
  logic [BW-1:0] addr_sum;

  cam_px_pack #(.DW(DW)) u_pack (
    .r  (r_lat),
    .g  (D[7:4]),
    .b  (D[3:0]),
    .px (px_packed)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_SYNC:   if (VSYNC) state_nxt = ST_BLANK;
      ST_BLANK:  if (!VSYNC) begin
                   state_nxt = ST_ACTIVE;
                   start     = 1'b1;
                 end
      ST_ACTIVE: if (VSYNC) begin
                   state_nxt = ST_BLANK;
                   done      = 1'b1;
                 end
      default:   state_nxt = ST_SYNC;
    endcase
  end

  assign active   = (state == ST_ACTIVE);
  assign in_range = (col < COL_MAX) && (row < ROW_MAX);

`ifdef CAM_CAPTURE_DECIM_EN
  // Only even input rows/columns land in memory; row_base advances after odd rows.
  assign keep     = ~col[0] & ~row[0];
  assign row_step = row[0];
  assign addr_sum = row_base + BW'(col >> 1);
`else
  assign keep     = 1'b1;
  assign row_step = 1'b1;
  assign addr_sum = row_base + BW'(col);
`endif

  always_ff @(posedge PCLK) begin
    if (rst) begin
      state       <= ST_SYNC;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      frame_done  <= 1'b0;
      err_ovf     <= 1'b0;
      col         <= '0;
      row         <= '0;
      row_base    <= '0;
      phase       <= 1'b0;
      r_lat       <= '0;
      href_d      <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= done;
      px_wr      <= 1'b0;
      href_d     <= HREF & active;
      if (start) begin
        col      <= '0;
        row      <= '0;
        row_base <= '0;
        phase    <= 1'b0;
      end else if (active) begin
        if (HREF) begin
          phase <= ~phase;
          if (!phase) begin
            r_lat <= D[3:0];
          end else if (in_range) begin
            col <= col + 1'b1;
            if (keep) begin
              px_wr       <= 1'b1;
              mem_px_addr <= addr_sum[AW-1:0];
              mem_px_data <= px_packed;
            end
          end else begin
            err_ovf <= 1'b1;
          end
        end else if (href_d) begin
          col   <= '0;
          phase <= 1'b0;
          if (row < ROW_MAX) begin
            row <= row + 1'b1;
            if (row_step) row_base <= row_base + ROW_INC;
          end
        end
      end
    end
  end

endmodule
